// File: rtl/dro_bank.sv
// dro_bank: multi-channel readout bank that latches input pulses and replays them after each tick.
// Define DRO_BANK_VIOL_CNT_EN to build the saturating viol_cnt counter; otherwise viol_cnt is tied to 0.
module dro_bank #(
  parameter int CH      = 4,
  parameter int SETUP   = 2,
  parameter int HOLD    = 1,
  parameter int DELAY   = 3,
  parameter int PULSE_W = 2,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CH-1:0]    d,
  input  logic             tick,
  input  logic [CH-1:0]    ndro,
  input  logic [CH-1:0]    clr,
  output logic [CH-1:0]    out,
  output logic [CH-1:0]    viol,
  output logic [CNT_W-1:0] viol_cnt
);

  localparam int SC_W = (SETUP > 1) ? $clog2(SETUP) : 1;
  localparam int HC_W = (HOLD > 0) ? $clog2(HOLD + 1) : 1;
  localparam int SW_W = $clog2(PULSE_W + 1);

  logic [CH-1:0]            state_q, state_d;
  logic [CH-1:0]            pend_q, pend_d;
  logic [CH-1:0]            viol_q, viol_d;
  logic [CH-1:0][SC_W-1:0]  pcnt_q, pcnt_d;
  logic [CH-1:0][HC_W-1:0]  hcnt_q, hcnt_d;
  logic [CH-1:0][SW_W-1:0]  st_q, st_d;
  logic [CH-1:0]            rd, st_in, in_hold, acc;

  // Per-channel capture, setup/hold checking and readout; clr overrides everything else.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    pcnt_d  = pcnt_q;
    hcnt_d  = hcnt_q;
    viol_d  = '0;
    rd      = '0;
    in_hold = '0;
    acc     = '0;
    for (int i = 0; i < CH; i++) begin
      in_hold[i] = (hcnt_q[i] != '0);
      if (tick)
        hcnt_d[i] = HC_W'(HOLD);
      else if (in_hold[i])
        hcnt_d[i] = hcnt_q[i] - HC_W'(1);
      acc[i] = d[i] & ~in_hold[i] & ~pend_q[i] & ~state_q[i];
      if (clr[i]) begin
        state_d[i] = 1'b0;
        pend_d[i]  = 1'b0;
        pcnt_d[i]  = '0;
      end else begin
        viol_d[i] = d[i] & in_hold[i];
        if (tick) begin
          // A pending (or same-cycle) event at tick is a setup violation and is dropped.
          if (pend_q[i] | acc[i]) begin
            viol_d[i] = 1'b1;
            pend_d[i] = 1'b0;
            pcnt_d[i] = '0;
          end else begin
            rd[i] = state_q[i];
            if (!ndro[i])
              state_d[i] = 1'b0;
          end
        end else if (pend_q[i]) begin
          if (pcnt_q[i] == '0) begin
            pend_d[i]  = 1'b0;
            state_d[i] = 1'b1;
          end else begin
            pcnt_d[i] = pcnt_q[i] - SC_W'(1);
          end
        end else if (acc[i]) begin
          if (SETUP == 0) begin
            state_d[i] = 1'b1;
          end else begin
            pend_d[i] = 1'b1;
            pcnt_d[i] = SC_W'((SETUP > 0) ? SETUP - 1 : 0);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= '0;
      pend_q  <= '0;
      pcnt_q  <= '0;
      hcnt_q  <= '0;
      viol_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      pcnt_q  <= pcnt_d;
      hcnt_q  <= hcnt_d;
      viol_q  <= viol_d;
    end
  end

  assign viol = viol_q;

  // Readout pipeline: DELAY-1 register stages, the stretcher supplies the last one.
  generate
    if (DELAY == 1) begin : g_nopipe
      assign st_in = rd;
    end else begin : g_pipe
      logic [DELAY-2:0][CH-1:0] pipe_q, pipe_d;
      always_comb begin
        pipe_d[0] = rd;
        for (int k = 1; k < DELAY - 1; k++)
          pipe_d[k] = pipe_q[k-1];
      end
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          pipe_q <= '0;
        else
          pipe_q <= pipe_d;
      end
      assign st_in = pipe_q[DELAY-2];
    end
  endgenerate

  always_comb begin
    st_d = st_q;
    out  = '0;
    for (int i = 0; i < CH; i++) begin
      if (st_in[i])
        st_d[i] = SW_W'(PULSE_W);
      else if (st_q[i] != '0)
        st_d[i] = st_q[i] - SW_W'(1);
      out[i] = (st_q[i] != '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      st_q <= '0;
    else
      st_q <= st_d;
  end

`ifdef DRO_BANK_VIOL_CNT_EN
  localparam int PC_W  = $clog2(CH + 1);
  localparam int SUM_W = CNT_W + PC_W;

  function automatic logic [PC_W-1:0] popcount(input logic [CH-1:0] v);
    logic [PC_W-1:0] n;
    n = '0;
    for (int i = 0; i < CH; i++)
      n = n + PC_W'(v[i]);
    return n;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [PC_W-1:0]  b);
    logic [SUM_W-1:0] s;
    s = SUM_W'(a) + SUM_W'(b);
    if (s > SUM_W'({CNT_W{1'b1}}))
      return {CNT_W{1'b1}};
    return s[CNT_W-1:0];
  endfunction

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = sat_add(cnt_q, popcount(viol_d));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign viol_cnt = cnt_q;
`else
  assign viol_cnt = '0;
`endif

endmodule

// File: tb/tb_dro_bank.sv
// Bench for dro_bank: directed vector table for the documented scenarios, then random traffic
// checked every cycle against a timestamp-based reference model.
module tb_dro_bank;

  localparam int CH    = 4;
  localparam int SETUP = 2;
  localparam int HOLD  = 1;
  localparam int DELAY = 3;
  localparam int PW    = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] d = '0, ndro = '0, clr = '0;
  logic       tick = 1'b0;
  logic [3:0] out, viol, out2, viol2;
  logic [7:0] vcnt;
  logic [1:0] vcnt2;

  dro_bank #(.CH(CH), .SETUP(SETUP), .HOLD(HOLD), .DELAY(DELAY), .PULSE_W(PW), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .d(d), .tick(tick), .ndro(ndro), .clr(clr),
    .out(out), .viol(viol), .viol_cnt(vcnt));

  dro_bank #(.CH(CH), .SETUP(SETUP), .HOLD(HOLD), .DELAY(DELAY), .PULSE_W(PW), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .d(d), .tick(tick), .ndro(ndro), .clr(clr),
    .out(out2), .viol(viol2), .viol_cnt(vcnt2));

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: event timestamps and a list of readouts, no counters or pipeline.
  typedef struct { int ch; int t; } ro_t;
  int         tm;
  int         pend_t [CH];
  bit         st [CH];
  int         last_tick;
  ro_t        ro_q[$];
  logic [3:0] viol_e;
  int         vcount;

  function automatic int cnt_exp(input int n, input int maxv);
`ifdef DRO_BANK_VIOL_CNT_EN
    return (n > maxv) ? maxv : n;
`else
    return 0 * n * maxv;
`endif
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < CH; i++) begin
      pend_t[i] = -1;
      st[i]     = 1'b0;
    end
    last_tick = -100;
    ro_q.delete();
    viol_e = '0;
    vcount = 0;
  endfunction

  function automatic logic [3:0] model_out();
    logic [3:0] o;
    o = '0;
    foreach (ro_q[k])
      if (tm >= ro_q[k].t + DELAY && tm <= ro_q[k].t + DELAY + PW - 1)
        o[ro_q[k].ch] = 1'b1;
    return o;
  endfunction

  function automatic void model_step(input logic r, input logic [3:0] dd, input logic tk,
                                     input logic [3:0] nd, input logic [3:0] cl);
    logic [3:0] vn;
    bit         ih;
    ro_t        e;
    if (r) begin
      model_reset();
      tm++;
      return;
    end
    for (int i = 0; i < CH; i++)
      if (pend_t[i] >= 0 && tm == pend_t[i] + SETUP + 1) begin
        st[i]     = 1'b1;
        pend_t[i] = -1;
      end
    ih = (tm - last_tick >= 1) && (tm - last_tick <= HOLD);
    vn = '0;
    for (int i = 0; i < CH; i++) begin
      if (cl[i]) begin
        st[i]     = 1'b0;
        pend_t[i] = -1;
      end else begin
        if (dd[i]) begin
          if (ih) vn[i] = 1'b1;
          else if (pend_t[i] < 0 && !st[i]) pend_t[i] = tm;
        end
        if (tk) begin
          if (pend_t[i] >= 0) begin
            vn[i]     = 1'b1;
            pend_t[i] = -1;
          end else if (st[i]) begin
            e.ch = i;
            e.t  = tm;
            ro_q.push_back(e);
            if (!nd[i]) st[i] = 1'b0;
          end
        end
      end
    end
    if (tk) last_tick = tm;
    viol_e = vn;
    vcount += $countones(vn);
    while (ro_q.size() > 0 && ro_q[0].t + DELAY + PW - 1 < tm)
      void'(ro_q.pop_front());
    tm++;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, tm, act, exp);
    end
  endtask

  // One clock cycle: drive at the falling edge, compare registered outputs just after.
  task automatic step(input logic r, input logic [3:0] dd, input logic tk,
                      input logic [3:0] nd, input logic [3:0] cl);
    logic [3:0] eo, ev;
    int         ec;
    @(negedge clk);
    rst = r; d = dd; tick = tk; ndro = nd; clr = cl;
    #1;
    eo = r ? 4'b0 : model_out();
    ev = r ? 4'b0 : viol_e;
    ec = r ? 0 : vcount;
    chk("out", 32'(out), 32'(eo));
    chk("viol", 32'(viol), 32'(ev));
    chk("viol_cnt", 32'(vcnt), 32'(cnt_exp(ec, 255)));
    chk("viol_cnt_w2", 32'(vcnt2), 32'(cnt_exp(ec, 3)));
    model_step(r, dd, tk, nd, cl);
  endtask

  typedef struct {
    int         cyc;
    logic [3:0] d;
    logic       tick;
    logic [3:0] clr;
    logic       rst;
    logic       chk;
    logic [3:0] eout;
    logic [3:0] eviol;
    int         ecnt;
  } vec_t;
  vec_t tbl[$];

  function automatic void stim(input int c, input logic [3:0] dd, input logic tk,
                               input logic [3:0] cl, input logic r);
    vec_t v;
    v = '{cyc: c, d: dd, tick: tk, clr: cl, rst: r, chk: 1'b0, eout: '0, eviol: '0, ecnt: -1};
    tbl.push_back(v);
  endfunction

  function automatic void expv(input int c, input logic [3:0] eo, input logic [3:0] ev, input int ec);
    vec_t v;
    v = '{cyc: c, d: '0, tick: 1'b0, clr: '0, rst: 1'b0, chk: 1'b1, eout: eo, eviol: ev, ecnt: ec};
    tbl.push_back(v);
  endfunction

  initial begin
    logic [3:0] dd, cl, nd;
    logic       tk, r;

    // Directed scenarios; cycle 0 is the first cycle after reset, ndro[1]=1 throughout.
    stim(2,  4'b0011, 1'b0, 4'b0000, 1'b0);
    stim(9,  4'b0100, 1'b0, 4'b0000, 1'b0);
    stim(10, 4'b0000, 1'b1, 4'b0000, 1'b0);
    stim(11, 4'b1000, 1'b0, 4'b0000, 1'b0);
    stim(20, 4'b0000, 1'b1, 4'b0000, 1'b0);
    stim(22, 4'b1000, 1'b0, 4'b0000, 1'b0);
    stim(25, 4'b0000, 1'b0, 4'b0010, 1'b0);
    stim(27, 4'b0100, 1'b0, 4'b0000, 1'b0);
    stim(30, 4'b0000, 1'b1, 4'b0000, 1'b0);
    stim(42, 4'b0001, 1'b0, 4'b0000, 1'b0);
    stim(50, 4'b0000, 1'b1, 4'b0000, 1'b0);
    stim(52, 4'b0000, 1'b0, 4'b0000, 1'b1);
    stim(60, 4'b1111, 1'b1, 4'b0000, 1'b0);
    stim(61, 4'b0001, 1'b0, 4'b0000, 1'b0);
    expv(11, 4'b0000, 4'b0100, 1);
    expv(12, 4'b0000, 4'b1000, 2);
    expv(13, 4'b0011, 4'b0000, 2);
    expv(14, 4'b0011, 4'b0000, -1);
    expv(15, 4'b0000, 4'b0000, -1);
    expv(23, 4'b0010, 4'b0000, -1);
    expv(24, 4'b0010, 4'b0000, -1);
    expv(25, 4'b0000, 4'b0000, -1);
    expv(33, 4'b1100, 4'b0000, -1);
    expv(34, 4'b1100, 4'b0000, -1);
    expv(35, 4'b0000, 4'b0000, 2);
    expv(52, 4'b0000, 4'b0000, 0);
    expv(53, 4'b0000, 4'b0000, 0);
    expv(54, 4'b0000, 4'b0000, -1);
    expv(61, 4'b0000, 4'b1111, 4);
    expv(62, 4'b0000, 4'b0001, 5);

    tm = 0;
    model_reset();
    #2 rst = 1'b1;
    for (int k = 0; k < 3; k++)
      step(1'b1, 4'b0, 1'b0, 4'b0, 4'b0);

    for (int c = 0; c < 66; c++) begin
      dd = '0; tk = 1'b0; cl = '0; r = 1'b0;
      foreach (tbl[k])
        if (!tbl[k].chk && tbl[k].cyc == c) begin
          dd |= tbl[k].d;
          tk |= tbl[k].tick;
          cl |= tbl[k].clr;
          r  |= tbl[k].rst;
        end
      step(r, dd, tk, 4'b0010, cl);
      foreach (tbl[k])
        if (tbl[k].chk && tbl[k].cyc == c) begin
          chk("tbl_out", 32'(out), 32'(tbl[k].eout));
          chk("tbl_viol", 32'(viol), 32'(tbl[k].eviol));
          if (tbl[k].ecnt >= 0) begin
            chk("tbl_cnt", 32'(vcnt), 32'(cnt_exp(tbl[k].ecnt, 255)));
            chk("tbl_cnt_w2", 32'(vcnt2), 32'(cnt_exp(tbl[k].ecnt, 3)));
          end
        end
    end

    // Random traffic against the model.
    nd = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < CH; i++) begin
        dd[i] = ($urandom_range(0, 4) == 0);
        cl[i] = ($urandom_range(0, 15) == 0);
      end
      if ($urandom_range(0, 19) == 0) nd = 4'($urandom);
      tk = ($urandom_range(0, 3) == 0);
      r  = ($urandom_range(0, 299) == 0);
      step(r, dd, tk, nd, cl);
    end
    step(1'b0, 4'b0, 1'b0, 4'b0, 4'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
